// File: rtl/ram_rd_check.sv
// ram_rd_check: sweeps RAM port B and checks each word against SEED + addr.
// Define RDCHK_ERR_CAPTURE_EN to add first_err_addr/first_err_data capture.
module ram_rd_check #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 512,
  parameter int RD_LAT = 1,
  parameter logic [DATA_W-1:0] SEED = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt
`ifdef RDCHK_ERR_CAPTURE_EN
  ,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   E_ONE = (ADDR_W + 1)'(1);

  state_t state, state_nxt;

  logic [RD_LAT-1:0] tag_vld;
  logic [ADDR_W-1:0] tag_addr [RD_LAT];

  logic              cmp_vld;
  logic [ADDR_W-1:0] cmp_addr;
  logic [DATA_W-1:0] exp_word;
  logic              mismatch;
  logic              go;
  logic              finish;
  logic [ADDR_W-1:0] addr_nxt;
  logic [ADDR_W:0]   err_nxt;

  assign cmp_vld  = tag_vld[RD_LAT-1];
  assign cmp_addr = tag_addr[RD_LAT-1];
  assign exp_word = SEED + DATA_W'(cmp_addr);
  assign mismatch = cmp_vld && (rd_data != exp_word);
  assign go       = start && (state == S_IDLE || state == S_DONE);
  assign finish   = (state == S_DRAIN) && (state_nxt == S_DONE);

  always_comb begin
    state_nxt = state;
    addr_nxt  = rd_addr;
    unique case (state)
      S_IDLE, S_DONE: begin
        addr_nxt = '0;
        if (start) state_nxt = S_READ;
      end
      S_READ: begin
        if (rd_addr == LAST) state_nxt = S_DRAIN;
        else addr_nxt = rd_addr + A_ONE;
      end
      S_DRAIN: begin
        // the last issued tag reaching the compare point ends the sweep
        if (cmp_vld && cmp_addr == LAST) begin
          state_nxt = S_DONE;
          addr_nxt  = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    err_nxt = err_cnt;
    if (go) err_nxt = '0;
    else if (mismatch) err_nxt = err_cnt + E_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      rd_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= '0;
    end else begin
      state   <= state_nxt;
      rd_addr <= addr_nxt;
      busy    <= (state_nxt == S_READ) || (state_nxt == S_DRAIN);
      done    <= (state_nxt == S_DONE);
      err_cnt <= err_nxt;
      if (go) pass <= 1'b0;
      else if (finish) pass <= (err_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_addr[i] <= '0;
    end else begin
      tag_vld[0]  <= (state == S_READ);
      tag_addr[0] <= rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_addr[i] <= tag_addr[i-1];
      end
    end
  end

`ifdef RDCHK_ERR_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if (go) begin
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if (mismatch && err_cnt == '0) begin
      first_err_addr <= cmp_addr;
      first_err_data <= rd_data;
    end
  end
`endif

endmodule

// File: tb/tb_ram_rd_check.sv
// tb_ram_rd_check: directed checks of ram_rd_check with behavioural RAMs.
// Three instances: RD_LAT=1/SEED=1, RD_LAT=3/SEED=FFFF, DEPTH=1/RD_LAT=2.
module tb_ram_rd_check;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_n;
  logic start_a, start_b, start_c;
  int   mode_a = 0;
  int   mode_c = 0;
  int   vecs = 0;
  int   errs = 0;

  logic [8:0]  rd_addr_a, rd_addr_b, rd_addr_c;
  logic [15:0] q_a = '0;
  logic [15:0] p1_b = '0, p2_b = '0, q_b = '0;
  logic [15:0] p1_c = '0, q_c = '0;
  logic        busy_a, done_a, pass_a;
  logic        busy_b, done_b, pass_b;
  logic        busy_c, done_c, pass_c;
  logic [9:0]  err_a, err_b, err_c;
`ifdef RDCHK_ERR_CAPTURE_EN
  logic [8:0]  fea_a, fea_b, fea_c;
  logic [15:0] fed_a, fed_b, fed_c;
`endif

  ram_rd_check #(.ADDR_W(9), .DATA_W(16), .DEPTH(512), .RD_LAT(1),
                 .SEED(16'd1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .rd_addr(rd_addr_a),
    .rd_data(q_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_cnt(err_a)
`ifdef RDCHK_ERR_CAPTURE_EN
    , .first_err_addr(fea_a), .first_err_data(fed_a)
`endif
  );

  ram_rd_check #(.ADDR_W(9), .DATA_W(16), .DEPTH(512), .RD_LAT(3),
                 .SEED(16'hFFFF)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .rd_addr(rd_addr_b),
    .rd_data(q_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_cnt(err_b)
`ifdef RDCHK_ERR_CAPTURE_EN
    , .first_err_addr(fea_b), .first_err_data(fed_b)
`endif
  );

  ram_rd_check #(.ADDR_W(9), .DATA_W(16), .DEPTH(1), .RD_LAT(2),
                 .SEED(16'd5)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .rd_addr(rd_addr_c),
    .rd_data(q_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .err_cnt(err_c)
`ifdef RDCHK_ERR_CAPTURE_EN
    , .first_err_addr(fea_c), .first_err_data(fed_c)
`endif
  );

  // mode 0: correct pattern, 1: bit0 flipped at address 100, 2: all zero
  function automatic logic [15:0] ram_word(input int mode,
                                           input logic [8:0] a,
                                           input logic [15:0] seed);
    logic [15:0] w;
    w = seed + {7'd0, a};
    if (mode == 1 && a == 9'd100) w = w ^ 16'h0001;
    if (mode == 2) w = 16'h0000;
    return w;
  endfunction

  always @(posedge clk) begin
    q_a  <= ram_word(mode_a, rd_addr_a, 16'd1);
    p1_b <= ram_word(0, rd_addr_b, 16'hFFFF);
    p2_b <= p1_b;
    q_b  <= p2_b;
    p1_c <= ram_word(mode_c, rd_addr_c, 16'd5);
    q_c  <= p1_c;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // start_a pulsed in cycle 0; optional extra start in cycle dup
  task automatic sweep_a(input int dup, input logic [9:0] exp_err,
                         input logic exp_pass);
    start_a = 1'b1;
    for (int k = 1; k <= 514; k++) begin
      step();
      if (k == 1) start_a = 1'b0;
      if (k == dup) start_a = 1'b1;
      if (k == dup + 1) start_a = 1'b0;
      if (k == 1) begin
        chk("a_clr_done", done_a, 0);
        chk("a_clr_err", err_a, 0);
        chk("a_clr_pass", pass_a, 0);
      end
      if (k <= 513) begin
        chk("a_rd_addr", rd_addr_a, (k <= 512) ? k - 1 : 511);
        chk("a_busy", busy_a, 1);
        chk("a_done_early", done_a, 0);
      end else begin
        chk("a_done", done_a, 1);
        chk("a_busy_end", busy_a, 0);
        chk("a_addr_end", rd_addr_a, 0);
        chk("a_pass", pass_a, exp_pass);
        chk("a_err_cnt", err_a, exp_err);
      end
    end
  endtask

  task automatic sweep_c(input logic [9:0] exp_err, input logic exp_pass);
    start_c = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 1) start_c = 1'b0;
      if (k <= 3) begin
        chk("c_rd_addr", rd_addr_c, 0);
        chk("c_busy", busy_c, 1);
        chk("c_done_early", done_c, 0);
      end else begin
        chk("c_done", done_c, 1);
        chk("c_pass", pass_c, exp_pass);
        chk("c_err_cnt", err_c, exp_err);
      end
    end
  endtask

  initial begin
    int seen;
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    repeat (3) step();
    chk("rst_addr", rd_addr_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_done_b", done_b, 0);
    chk("rst_busy_c", busy_c, 0);
    rst_n = 1'b1;
    step();

    // clean sweep
    mode_a = 0;
    sweep_a(0, 10'd0, 1'b1);
    repeat (5) step();
    chk("a_done_hold", done_a, 1);
    chk("a_pass_hold", pass_a, 1);

    // single flipped bit at address 100
    mode_a = 1;
    sweep_a(0, 10'd1, 1'b0);
`ifdef RDCHK_ERR_CAPTURE_EN
    chk("a_fe_addr_100", fea_a, 100);
    chk("a_fe_data_100", fed_a, 100);
`endif

    // every word wrong: count reaches DEPTH
    mode_a = 2;
    sweep_a(0, 10'd512, 1'b0);
`ifdef RDCHK_ERR_CAPTURE_EN
    chk("a_fe_addr_0", fea_a, 0);
    chk("a_fe_data_0", fed_a, 0);
`endif
    repeat (3) step();
    chk("a_err_hold", err_a, 512);
    chk("a_done_hold2", done_a, 1);

    // restart from DONE with an ignored start in cycle 200
    mode_a = 0;
    sweep_a(200, 10'd0, 1'b1);
`ifdef RDCHK_ERR_CAPTURE_EN
    chk("a_fe_clr_addr", fea_a, 0);
    chk("a_fe_clr_data", fed_a, 0);
`endif

    // reset in cycle 300 of a failing sweep
    mode_a = 2;
    start_a = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      step();
      if (k == 1) start_a = 1'b0;
      if (k == 300) begin
        chk("a_err_mid", err_a, 298);
        chk("a_busy_mid", busy_a, 1);
        rst_n = 1'b0;
      end
    end
    step();
    rst_n = 1'b1;
    chk("a_rst_addr", rd_addr_a, 0);
    chk("a_rst_busy", busy_a, 0);
    chk("a_rst_done", done_a, 0);
    chk("a_rst_err", err_a, 0);
    chk("a_rst_pass", pass_a, 0);
`ifdef RDCHK_ERR_CAPTURE_EN
    chk("a_rst_fe_addr", fea_a, 0);
    chk("a_rst_fe_data", fed_a, 0);
`endif
    seen = 0;
    for (int k = 0; k < 600; k++) begin
      step();
      if (done_a !== 1'b0 || busy_a !== 1'b0) seen++;
    end
    chk("a_no_done_after_rst", seen, 0);

    // RD_LAT=3, SEED=FFFF: expected wraps to 0 at address 1
    start_b = 1'b1;
    for (int k = 1; k <= 516; k++) begin
      step();
      if (k == 1) start_b = 1'b0;
      if (k == 1) chk("b_addr_c1", rd_addr_b, 0);
      if (k == 2) chk("b_addr_c2", rd_addr_b, 1);
      if (k == 512) chk("b_addr_c512", rd_addr_b, 511);
      if (k == 515) begin
        chk("b_done_early", done_b, 0);
        chk("b_busy_drain", busy_b, 1);
      end
      if (k == 516) begin
        chk("b_done", done_b, 1);
        chk("b_pass", pass_b, 1);
        chk("b_err", err_b, 0);
        chk("b_addr_end", rd_addr_b, 0);
      end
    end

    // DEPTH=1: good word then wrong word (second start from DONE)
    mode_c = 0;
    sweep_c(10'd0, 1'b1);
    mode_c = 2;
    sweep_c(10'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
